key_schedule: RTL and testbench

KEY_SCHEDULE -- requirements
Module: key_schedule

---
 rtl/key_schedule_if.sv | 26 ++
 rtl/key_schedule.sv | 142 ++++++++++++++
 tb/tb_key_schedule.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_schedule_if.sv
// Handshake bundle for the AES-128 key schedule: start/key request plus round-key stream.
// Optional read-back port for the round-key store is present only with KEY_SCHEDULE_STORE_EN.
interface key_schedule_if;
  logic         start;
  logic [127:0] key_in;
  logic         rk_ready;
  logic         rk_valid;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         busy;
  logic         done;
`ifdef KEY_SCHEDULE_STORE_EN
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;

  modport master (output start, key_in, rk_ready, rd_idx,
                  input  rk_valid, rk_out, rk_idx, busy, done, rd_key);
  modport slave  (input  start, key_in, rk_ready, rd_idx,
                  output rk_valid, rk_out, rk_idx, busy, done, rd_key);
`else
  modport master (output start, key_in, rk_ready,
                  input  rk_valid, rk_out, rk_idx, busy, done);
  modport slave  (input  start, key_in, rk_ready,
                  output rk_valid, rk_out, rk_idx, busy, done);
`endif
endinterface

// File: rtl/key_schedule.sv
// AES-128 key expansion streaming round keys 0..10 over a valid/ready handshake.
// Define KEY_SCHEDULE_STORE_EN to add an 11-entry round-key store with combinational read-back.
module key_schedule (
  input logic         clk,
  input logic         rst,
  key_schedule_if.slave ks
);
  // state | meaning
  // IDLE  | waiting for start
  // EMIT  | presenting round key rk_idx, advancing on each transfer
  // DONE  | one-cycle done pulse after round key 10 transferred
  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_e;

  state_e       state_q;
  logic [127:0] key_q, key_d;
  logic [3:0]   idx_q;
  logic [7:0]   rcon_q, rcon_d;
  logic         valid_q, busy_q, done_q;
  logic [31:0]  rot_w, sub_w, t_w, n0, n1, n2, n3;
  logic         accept, xfer;

  assign rot_w = {key_q[23:0], key_q[31:24]};

  sub_word u_sub_word (
    .word_i (rot_w),
    .word_o (sub_w)
  );

  always_comb begin
    t_w    = sub_w ^ {rcon_q, 24'h0};
    n0     = key_q[127:96] ^ t_w;
    n1     = key_q[95:64]  ^ n0;
    n2     = key_q[63:32]  ^ n1;
    n3     = key_q[31:0]   ^ n2;
    key_d  = {n0, n1, n2, n3};
    rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
  end

  // busy is low in IDLE and DONE, so a start in the DONE cycle is taken
  assign accept = ks.start & ~busy_q;
  assign xfer   = valid_q & ks.rk_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      rcon_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (accept) begin
      state_q <= EMIT;
      key_q   <= ks.key_in;
      idx_q   <= 4'd0;
      rcon_q  <= 8'h01;
      valid_q <= 1'b1;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        EMIT: begin
          if (xfer) begin
            if (idx_q == 4'd10) begin
              state_q <= DONE;
              key_q   <= '0;
              idx_q   <= 4'd0;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              key_q  <= key_d;
              idx_q  <= idx_q + 4'd1;
              rcon_q <= rcon_d;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ks.rk_valid = valid_q;
  assign ks.rk_out   = key_q;
  assign ks.rk_idx   = idx_q;
  assign ks.busy     = busy_q;
  assign ks.done     = done_q;

`ifdef KEY_SCHEDULE_STORE_EN
  logic [127:0] store_q [0:10];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 11; i++) store_q[i] <= '0;
    end else if (xfer) begin
      store_q[idx_q] <= key_q;
    end
  end

  assign ks.rd_key = (ks.rd_idx <= 4'd10) ? store_q[ks.rd_idx] : '0;
`endif

endmodule

// Four-byte AES S-box substitution; S-box computed as GF(2^8) inverse followed by the affine map.
module sub_word (
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction

  // a^254 is the multiplicative inverse (and maps 0 to 0)
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq, inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  always_comb begin
    word_o = {sbox(word_i[31:24]), sbox(word_i[23:16]),
              sbox(word_i[15:8]),  sbox(word_i[7:0])};
  end
endmodule

// File: tb/tb_key_schedule.sv
// Scoreboard bench for key_schedule: a word-array AES key expansion model feeds an expected queue,
// a negedge monitor pops and compares on every handshake transfer.
module tb_key_schedule;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  key_schedule_if ks();

  key_schedule dut (
    .clk (clk),
    .rst (rst),
    .ks  (ks)
  );

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] key;
  } exp_t;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_K1  = 128'h62636363626363636263636362636363;

  exp_t         exp_q[$];
  logic [7:0]   sbox_m [0:255];
  logic [127:0] seen [0:10];
  int           n_cmp = 0;
  int           n_err = 0;
  bit           expect_done = 0;
  bit           prev_stall = 0;
  logic [3:0]   prev_idx;
  logic [127:0] prev_key;
  int           rmode = 0;
  int           pat_i = 0;
  int           done_seen = 0;

  task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = (v << n) | (v >> (8 - n));
    return r;
  endfunction

  // S-box by walking generator 3 and its inverse in lockstep
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
      sbox_m[p] = x;
    end while (p != 8'h01);
    sbox_m[0] = 8'h63;
  endtask

  task automatic push_expansion(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [7:0]  rc [0:9];
    logic [31:0] tmp;
    exp_t        e;
    rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_m[tmp[31:24]], sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]]};
        tmp = tmp ^ {rc[i/4 - 1], 24'h0};
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) begin
      e.idx = 4'(r);
      e.key = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      exp_q.push_back(e);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stall  = 0;
      expect_done = 0;
    end else begin
      if (ks.done) done_seen++;
      if (expect_done) begin
        check("done_pulse", {ks.done, ks.rk_valid, ks.busy}, {1'b1, 1'b0, 1'b0});
        expect_done = 0;
      end else if (ks.done) begin
        check("unexpected_done", ks.done, 1'b0);
      end
      if (prev_stall)
        check("hold", {ks.rk_valid, ks.rk_idx, ks.rk_out}, {1'b1, prev_idx, prev_key});
      if (!ks.rk_valid) check("out_zero_idle", ks.rk_out, '0);
      if (ks.rk_valid && ks.rk_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_transfer", ks.rk_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("round_key", {ks.rk_idx, ks.rk_out}, {e.idx, e.key});
          seen[ks.rk_idx] = ks.rk_out;
          if (ks.rk_idx == 4'd10) expect_done = 1;
        end
      end
      prev_stall = ks.rk_valid && !ks.rk_ready;
      prev_idx   = ks.rk_idx;
      prev_key   = ks.rk_out;
    end
  end

  // rk_ready driver
  initial begin
    int pat [0:3];
    pat = '{1, 0, 0, 1};
    ks.rk_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        1:       begin ks.rk_ready = pat[pat_i % 4] != 0; pat_i++; end
        2:       ks.rk_ready = $urandom_range(0, 1) != 0;
        default: ks.rk_ready = 1'b1;
      endcase
    end
  end

  task automatic issue(input logic [127:0] key);
    @(posedge clk); #1;
    ks.start  = 1'b1;
    ks.key_in = key;
    push_expansion(key);
    @(posedge clk); #1;
    ks.start = 1'b0;
  endtask

  task automatic drain(input int budget);
    int c = 0;
    while ((exp_q.size() != 0 || expect_done) && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    if (exp_q.size() != 0 || expect_done) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      expect_done = 0;
    end
  endtask

  task automatic wait_idx(input logic [3:0] idx, input int budget);
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!(ks.rk_valid && ks.rk_idx == idx) && c < budget);
    if (!(ks.rk_valid && ks.rk_idx == idx)) check("wait_idx_timeout", ks.rk_idx, idx);
  endtask

  initial begin
    int c;
    build_sbox();
    ks.start  = 1'b0;
    ks.key_in = '0;
`ifdef KEY_SCHEDULE_STORE_EN
    ks.rd_idx = '0;
`endif
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {ks.rk_valid, ks.rk_idx, ks.rk_out, ks.busy, ks.done}, '0);
    rst = 1'b0;

    // Reference vector, always ready: latency and cycle-exact stream
    rmode = 0;
    issue(FIPS_KEY);
    check("first_key", {ks.rk_valid, ks.busy, ks.rk_idx, ks.rk_out}, {1'b1, 1'b1, 4'd0, FIPS_KEY});
    repeat (10) @(posedge clk);
    #1;
    check("idx10_after_10", {ks.rk_valid, ks.rk_idx}, {1'b1, 4'd10});
    @(posedge clk); #1;
    check("done_next_cycle", {ks.done, ks.busy, ks.rk_valid}, {1'b1, 1'b0, 1'b0});
    drain(20);
    check("fips_k1", seen[1], FIPS_K1);
    check("fips_k10", seen[10], FIPS_K10);
`ifdef KEY_SCHEDULE_STORE_EN
    ks.rd_idx = 4'd10; #1;
    check("store_rd10", ks.rd_key, FIPS_K10);
    ks.rd_idx = 4'd15; #1;
    check("store_rd15", ks.rd_key, '0);
    ks.rd_idx = 4'd0; #1;
    check("store_rd0", ks.rd_key, FIPS_KEY);
`endif

    // Ready toggling 1,0,0,1
    rmode = 1;
    pat_i = 0;
    issue(FIPS_KEY);
    drain(200);
    rmode = 0;

    // start while busy is ignored
    issue(FIPS_KEY);
    wait_idx(4'd4, 50);
    ks.start  = 1'b1;
    ks.key_in = '0;
    @(posedge clk); #1;
    ks.start = 1'b0;
    drain(50);
    check("ignored_start_k10", seen[10], FIPS_K10);

    // Reset mid-expansion aborts without done
    issue(FIPS_KEY);
    wait_idx(4'd6, 50);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", {ks.rk_valid, ks.rk_idx, ks.rk_out, ks.busy, ks.done}, '0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    done_seen = 0;
    repeat (6) @(posedge clk);
    #1;
    check("no_done_after_abort", 32'(done_seen), 32'd0);
    seen[1] = '0;
    issue('0);
    drain(50);
    check("zero_key_k1", seen[1], ZERO_K1);

    // start held through the DONE cycle restarts immediately
    @(posedge clk); #1;
    ks.start  = 1'b1;
    ks.key_in = FIPS_KEY;
    push_expansion(FIPS_KEY);
    push_expansion(FIPS_KEY);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!ks.done && c < 50);
    check("held_start_done", ks.done, 1'b1);
    @(posedge clk); #1;
    ks.start = 1'b0;
    check("restart_from_done", {ks.rk_valid, ks.rk_idx}, {1'b1, 4'd0});
    drain(50);

    // Random keys with random back-pressure
    rmode = 2;
    for (int k = 0; k < 6; k++) begin
      issue({$urandom, $urandom, $urandom, $urandom});
      drain(400);
    end
    rmode = 0;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
